bcd_display_scan_ctrl: RTL and testbench



---
 rtl/bcd_display_scan_ctrl.sv | 118 +++++++++++
 tb/tb_bcd_display_scan_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan_ctrl.sv
// bcd_display_scan_ctrl: sequential double-dabble of a signed magnitude with blanking/sign formatting,
// time-multiplexed onto a 4-digit common-anode display through one shared BCD decoder.
module bcd_display_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int VAL_W    = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [VAL_W-1:0] value,
    input  logic             neg,
    output logic             busy,
    output logic             done,
    output logic [3:0]       bcd_code,
    output logic [3:0]       an
);
    localparam int CW = $clog2(VAL_W + 1);
    localparam int PW = $clog2(SCAN_DIV);
    typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;
    state_t state_q, state_d;
    logic [VAL_W-1:0] sh_q, sh_d, mag_q, mag_d;
    logic neg_q, neg_d, busy_q, busy_d, done_q, done_d, ovf, wrap;
    logic [15:0] acc_q, acc_d, adj;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0] idx_q, idx_d, msd;
    logic [3:0] an_q, an_d, code_q, code_d;
    logic [3:0] dig_q [4];
    logic [3:0] dig_d [4];
    logic [3:0] fmt [4];
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < 4; i++)
            adj[4*i+:4] = acc_q[4*i+:4] >= 4'd5 ? acc_q[4*i+:4] + 4'd3 : acc_q[4*i+:4];
        msd = acc_q[15:12] != 4'd0 ? 2'd3 : acc_q[11:8] != 4'd0 ? 2'd2 : acc_q[7:4] != 4'd0 ? 2'd1 : 2'd0;
        ovf = 32'(mag_q) > 9999 || (neg_q && 32'(mag_q) > 999);
        // Positions above the most significant digit are blank, except one dash for a negative value
        for (int i = 0; i < 4; i++)
            fmt[i] = ovf ? 4'd10 : i <= 32'(msd) ? acc_q[4*i+:4] :
                     (neg_q && mag_q != '0 && i == 32'(msd) + 1) ? 4'd10 : 4'd11;
    end
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (load) begin
                sh_d    = value;
                mag_d   = value;
                neg_d   = neg;
                acc_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                acc_d   = {adj[14:0], sh_q[VAL_W-1]};
                sh_d    = sh_q << 1;
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(VAL_W - 1) ? FORMAT : SHIFT;
            end
            FORMAT: begin
                dig_d   = fmt;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        wrap   = pre_q == PW'(SCAN_DIV - 1);
        pre_d  = wrap ? '0 : pre_q + 1'b1;
        idx_d  = wrap ? idx_q + 2'd1 : idx_q;
        an_d   = wrap ? ~(4'b0001 << idx_q) : an_q;
        // Reading dig_d lets a same-edge FORMAT show the new digit set immediately
        code_d = wrap ? dig_d[idx_q] : code_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '{default: 4'd11};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pre_q   <= '0;
            idx_q   <= 2'd0;
            an_q    <= 4'b1111;
            code_q  <= 4'd11;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            code_q  <= code_d;
        end
    end
    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_code = code_q;
    assign an       = an_q;
endmodule

// File: tb/tb_bcd_display_scan_ctrl.sv
// tb_bcd_display_scan_ctrl: randomized and directed checks of conversion timing, formatting and scanning
// against a decimal-arithmetic display model.
module tb_bcd_display_scan_ctrl;
    localparam int VAL_W    = 14;
    localparam int SCAN_DIV = 4;
    logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, neg = 1'b0;
    logic [VAL_W-1:0] value = '0;
    logic busy, done;
    logic [3:0] bcd_code, an;
    int checks = 0, errors = 0;
    logic [3:0] cur_exp [4];

    bcd_display_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .VAL_W(VAL_W)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .neg(neg),
        .busy(busy), .done(done), .bcd_code(bcd_code), .an(an)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_code(input int v, input bit n, input int pos);
        int d [4];
        int len;
        if (v > 9999 || (n && v > 999)) return 4'd10;
        for (int k = 0; k < 4; k++) d[k] = (v / (10 ** k)) % 10;
        len = 1;
        for (int k = 1; k < 4; k++) if (d[k] != 0) len = k + 1;
        if (pos < len) return 4'(d[pos]);
        if (n && v != 0 && pos == len) return 4'd10;
        return 4'd11;
    endfunction

    function automatic int an_idx(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic check_display(input string name);
        int idx;
        repeat (5) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            idx = an_idx(an);
            checks++;
            if (idx < 0) begin
                errors++;
                $display("FAIL %s an=%b required one-hot-low anode", name, an);
            end else if (bcd_code !== cur_exp[idx]) begin
                errors++;
                $display("FAIL %s digit%0d code=%0d required %0d", name, idx, bcd_code, cur_exp[idx]);
            end
            @(negedge clk);
        end
    endtask

    task automatic do_conv(input int v, input bit n, input string name);
        int idx;
        load = 1'b1; value = v[VAL_W-1:0]; neg = n;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_phase cyc%0d busy=%b done=%b required busy=1 done=0", name, k + 1, busy, done);
            end
            idx = an_idx(an);
            if (idx >= 0) begin
                checks++;
                if (bcd_code !== cur_exp[idx]) begin
                    errors++;
                    $display("FAIL %s old_display digit%0d code=%0d required %0d", name, idx, bcd_code, cur_exp[idx]);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse done=%b busy=%b required done=1 busy=0", name, done, busy);
        end
        for (int i = 0; i < 4; i++) cur_exp[i] = exp_code(v, n, i);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width done=%b required 0", name, done);
        end
        check_display(name);
    endtask

    task automatic test_reset;
        logic [3:0] e;
        rst_n = 1'b0; load = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (an !== 4'b1111 || bcd_code !== 4'd11 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state an=%b code=%0d busy=%b done=%b required an=1111 code=11 busy=0 done=0",
                     an, bcd_code, busy, done);
        end
        rst_n = 1'b1;
        for (int k = 1; k < 25; k++) begin
            @(negedge clk);
            e = k < 4 ? 4'b1111 : ~(4'b0001 << ((k / 4 - 1) % 4));
            checks++;
            if (an !== e || bcd_code !== 4'd11) begin
                errors++;
                $display("FAIL reset_scan cyc%0d an=%b code=%0d required an=%b code=11", k, an, bcd_code, e);
            end
        end
        for (int i = 0; i < 4; i++) cur_exp[i] = 4'd11;
    endtask

    task automatic test_directed;
        do_conv(42, 1'b0, "v42");
        do_conv(7, 1'b1, "neg7");
        do_conv(0, 1'b1, "neg0");
        do_conv(1234, 1'b1, "neg1234");
        do_conv(12000, 1'b0, "v12000");
        do_conv(9999, 1'b0, "v9999");
        do_conv(999, 1'b1, "neg999");
        do_conv(1000, 1'b1, "neg1000");
        do_conv(10000, 1'b0, "v10000");
        do_conv(16383, 1'b0, "vmax");
    endtask

    task automatic test_random;
        int v;
        bit n;
        for (int r = 0; r < 12; r++) begin
            v = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, 999)) : int'($urandom_range(0, 16383));
            n = 1'($urandom_range(0, 1));
            do_conv(v, n, "random");
        end
    endtask

    task automatic test_back_to_back;
        int dones;
        load = 1'b1; value = 14'd321; neg = 1'b0;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        load = 1'b1; value = 14'd8; neg = 1'b1;
        @(negedge clk);
        load = 1'b0;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL back_to_back_dones count=%0d required 1", dones);
        end
        for (int i = 0; i < 4; i++) cur_exp[i] = exp_code(321, 1'b0, i);
        check_display("back_to_back_first");
        do_conv(55, 1'b1, "after_ignored");
    endtask

    task automatic test_reset_mid;
        int dones;
        load = 1'b1; value = 14'd777; neg = 1'b0;
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || an !== 4'b1111 || bcd_code !== 4'd11) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b an=%b code=%0d required busy=0 done=0 an=1111 code=11",
                     busy, done, an, bcd_code);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cur_exp[i] = 4'd11;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_mid_done count=%0d required 0", dones);
        end
        check_display("reset_mid_blank");
        do_conv(808, 1'b1, "after_reset");
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
